// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage core. It detects load-use hazards that
// forwarding cannot cover, serializes I-cache and D-cache refills onto the
// single backend port, and drives every pipeline stall/flush enable and the
// PC hold.
//
// Ports
//   clk, reset           core clock, synchronous active-high reset
//   rs1ID, rs2ID         ID-stage source registers
//   usesRs1ID/usesRs2ID  ID instruction really reads rs1/rs2
//   rdEX, memReadEX      EX destination register / EX is a load
//   branchTakenEX        EX resolved a taken branch/jump this cycle
//   icacheMiss           I-cache miss on the current fetch (level)
//   dcacheMiss           D-cache miss on the MEM access (level)
//   memReady             backend refill complete (1-cycle pulse)
//   memReqI, memReqD     backend refill requests (registered)
//   stallPC..stallEXMEM  hold the PC / pipeline registers (combinational)
//   flushIFID, flushIDEX load a bubble into the register (combinational)
//   stallCycles          cycles with stallPC=1 (saturating)
//   missCount            entries into DWAIT or IWAIT (saturating)
//
// Configuration macro: HAZARD_PERF_CNT_EN builds the performance counters;
// without it both counter ports are tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; load-use / branch / miss detection
// DWAIT    | D-refill in flight, whole pipeline frozen
// IWAIT    | I-refill in flight, front end held, bubbles enter EX
// IWAIT_DP | I-refill in flight with a D-miss queued behind it

module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1ID,
   input  logic [4:0]       rs2ID,
   input  logic             usesRs1ID,
   input  logic             usesRs2ID,
   input  logic [4:0]       rdEX,
   input  logic             memReadEX,
   input  logic             branchTakenEX,
   input  logic             icacheMiss,
   input  logic             dcacheMiss,
   input  logic             memReady,
   output logic             memReqI,
   output logic             memReqD,
   output logic             stallPC,
   output logic             stallIFID,
   output logic             stallIDEX,
   output logic             stallEXMEM,
   output logic             flushIFID,
   output logic             flushIDEX,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] missCount
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DWAIT    = 2'd1,
      IWAIT    = 2'd2,
      IWAIT_DP = 2'd3
   } state_t;

   state_t state;
   logic   loadUse;

   assign loadUse = memReadEX && (rdEX != 5'd0) &&
                    ((usesRs1ID && (rs1ID == rdEX)) ||
                     (usesRs2ID && (rs2ID == rdEX)));

   // Refill requests are registered alongside the state so they rise the
   // cycle after the miss is sampled and fall the cycle after memReady.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         memReqI <= 1'b0;
         memReqD <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (dcacheMiss) begin
                  state   <= DWAIT;
                  memReqD <= 1'b1;
               end else if (icacheMiss) begin
                  state   <= IWAIT;
                  memReqI <= 1'b1;
               end
            end
            DWAIT: begin
               if (memReady) begin
                  state   <= RUN;
                  memReqD <= 1'b0;
               end
            end
            IWAIT: begin
               if (memReady) begin
                  memReqI <= 1'b0;
                  if (dcacheMiss) begin
                     state   <= DWAIT;
                     memReqD <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end else if (dcacheMiss) begin
                  state <= IWAIT_DP;
               end
            end
            IWAIT_DP: begin
               if (memReady) begin
                  state   <= DWAIT;
                  memReqI <= 1'b0;
                  memReqD <= 1'b1;
               end
            end
            default: begin
               state   <= RUN;
               memReqI <= 1'b0;
               memReqD <= 1'b0;
            end
         endcase
      end
   end

   // Stall/flush decode. In RUN a miss wins over branch and load-use: a D-miss
   // freezes everything this cycle (MEM did not complete), an I-miss holds the
   // front end. In IWAIT a taken branch releases the PC for one cycle so the
   // target is captured while the refill keeps running.
   always_comb begin
      stallPC    = 1'b0;
      stallIFID  = 1'b0;
      stallIDEX  = 1'b0;
      stallEXMEM = 1'b0;
      flushIFID  = 1'b0;
      flushIDEX  = 1'b0;
      case (state)
         RUN: begin
            if (dcacheMiss) begin
               stallPC    = 1'b1;
               stallIFID  = 1'b1;
               stallIDEX  = 1'b1;
               stallEXMEM = 1'b1;
            end else if (icacheMiss) begin
               stallPC   = 1'b1;
               stallIFID = 1'b1;
               flushIDEX = 1'b1;
            end else if (branchTakenEX) begin
               flushIFID = 1'b1;
               flushIDEX = 1'b1;
            end else if (loadUse) begin
               stallPC   = 1'b1;
               stallIFID = 1'b1;
               flushIDEX = 1'b1;
            end
         end
         IWAIT: begin
            stallPC   = !branchTakenEX;
            stallIFID = 1'b1;
            flushIDEX = 1'b1;
         end
         DWAIT, IWAIT_DP: begin
            stallPC    = 1'b1;
            stallIFID  = 1'b1;
            stallIDEX  = 1'b1;
            stallEXMEM = 1'b1;
         end
         default: begin
            stallPC = 1'b0;
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   logic missEntry;

   assign missEntry = ((state == RUN)      && (dcacheMiss || icacheMiss)) ||
                      ((state == IWAIT)    && memReady && dcacheMiss) ||
                      ((state == IWAIT_DP) && memReady);

   always_ff @(posedge clk) begin
      if (reset) begin
         stallCycles <= '0;
         missCount   <= '0;
      end else begin
         if (stallPC && (stallCycles != '1)) begin
            stallCycles <= stallCycles + 1'b1;
         end
         if (missEntry && (missCount != '1)) begin
            missCount <= missCount + 1'b1;
         end
      end
   end
`else
   assign stallCycles = '0;
   assign missCount   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   localparam int CNT_W = 16;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] rs1ID = '0, rs2ID = '0, rdEX = '0;
   logic usesRs1ID = 1'b0, usesRs2ID = 1'b0, memReadEX = 1'b0;
   logic branchTakenEX = 1'b0, icacheMiss = 1'b0, dcacheMiss = 1'b0, memReady = 1'b0;
   logic memReqI, memReqD, stallPC, stallIFID, stallIDEX, stallEXMEM, flushIFID, flushIDEX;
   logic [CNT_W-1:0] stallCycles, missCount;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .rs1ID(rs1ID), .rs2ID(rs2ID), .usesRs1ID(usesRs1ID), .usesRs2ID(usesRs2ID),
      .rdEX(rdEX), .memReadEX(memReadEX), .branchTakenEX(branchTakenEX),
      .icacheMiss(icacheMiss), .dcacheMiss(dcacheMiss), .memReady(memReady),
      .memReqI(memReqI), .memReqD(memReqD),
      .stallPC(stallPC), .stallIFID(stallIFID), .stallIDEX(stallIDEX), .stallEXMEM(stallEXMEM),
      .flushIFID(flushIFID), .flushIDEX(flushIDEX),
      .stallCycles(stallCycles), .missCount(missCount)
   );

   typedef struct packed {
      logic             chk;
      logic [7:0]       ctl;   // {reqI,reqD,sPC,sIFID,sIDEX,sEXMEM,fIFID,fIDEX}
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] mc;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int passed = 0;
   int cyc = 0;

   // Reference model: which refills are outstanding, not the RTL state names.
   bit dBusy = 0, iBusy = 0, dQueued = 0;
   int nStall = 0, nMiss = 0;

   task automatic model(output exp_t e);
      bit lu, sPC, sIF, sID, sEX, fIF, fID, nD, nI, nQ, newMiss;
      lu = memReadEX && (rdEX != 0) &&
           ((usesRs1ID && rs1ID == rdEX) || (usesRs2ID && rs2ID == rdEX));
      {sPC, sIF, sID, sEX, fIF, fID} = '0;
      nD = dBusy; nI = iBusy; nQ = dQueued; newMiss = 0;
      if (dBusy) begin
         {sPC, sIF, sID, sEX} = 4'hF;
         if (memReady) nD = 0;
      end else if (iBusy && dQueued) begin
         {sPC, sIF, sID, sEX} = 4'hF;
         if (memReady) begin nI = 0; nQ = 0; nD = 1; newMiss = 1; end
      end else if (iBusy) begin
         sPC = !branchTakenEX; sIF = 1; fID = 1;
         if (memReady) begin
            nI = 0;
            if (dcacheMiss) begin nD = 1; newMiss = 1; end
         end else if (dcacheMiss) nQ = 1;
      end else begin
         if (dcacheMiss) begin {sPC, sIF, sID, sEX} = 4'hF; nD = 1; newMiss = 1; end
         else if (icacheMiss) begin sPC = 1; sIF = 1; fID = 1; nI = 1; newMiss = 1; end
         else if (branchTakenEX) begin fIF = 1; fID = 1; end
         else if (lu) begin sPC = 1; sIF = 1; fID = 1; end
      end
      e.chk = !reset;
      e.ctl = {iBusy, dBusy, sPC, sIF, sID, sEX, fIF, fID};
`ifdef HAZARD_PERF_CNT_EN
      e.sc = nStall[CNT_W-1:0];
      e.mc = nMiss[CNT_W-1:0];
`else
      e.sc = '0;
      e.mc = '0;
`endif
      if (reset) begin
         dBusy = 0; iBusy = 0; dQueued = 0; nStall = 0; nMiss = 0;
      end else begin
         dBusy = nD; iBusy = nI; dQueued = nQ;
         if (sPC && nStall < SAT) nStall++;
         if (newMiss && nMiss < SAT) nMiss++;
      end
   endtask

   task automatic drive(input bit r, bit br, bit im, bit dm, bit mr,
                        bit ml, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                        bit u1, bit u2);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; branchTakenEX = br; icacheMiss = im; dcacheMiss = dm; memReady = mr;
      memReadEX = ml; rdEX = rd; rs1ID = r1; rs2ID = r2; usesRs1ID = u1; usesRs2ID = u2;
      model(e);
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare it with
   // the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk) begin
               checks++;
               if ({memReqI, memReqD, stallPC, stallIFID, stallIDEX, stallEXMEM,
                    flushIFID, flushIDEX} === e.ctl) passed++;
               else $display("FAIL ctl cycle %0d: got %b expected %b", cyc,
                             {memReqI, memReqD, stallPC, stallIFID, stallIDEX, stallEXMEM,
                              flushIFID, flushIDEX}, e.ctl);
               checks++;
               if (stallCycles === e.sc && missCount === e.mc) passed++;
               else $display("FAIL counters cycle %0d: got stall=%0d miss=%0d expected stall=%0d miss=%0d",
                             cyc, stallCycles, missCount, e.sc, e.mc);
            end
         end
      end
   end

   initial begin
      int waitCnt;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs2, then rdEX=0 with same pattern
      drive(0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
      idle(1);
      drive(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
      drive(0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2, 1, 0);
      // load-use plus taken branch
      drive(0, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1);
      idle(1);
      // D-miss with memReady 10 cycles later
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // simultaneous I and D miss
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // IWAIT, D-miss at cycle 3, memReady at cycle 6
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // reset in DWAIT, then a stray memReady
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 1) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
      end
      idle(1);
      waitCnt = 0;
      while (sbq.size() > 0 && waitCnt < 10) begin
         @(negedge clk);
         waitCnt++;
      end
      @(posedge clk);
      checks++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL drain: got %0d pending expected 0", sbq.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
